// File: rtl/des_round_seq.sv
// Iterative DES Feistel round sequencer sharing one external f-function.
// Optional abort port: define DES_ROUND_SEQ_ABORT_EN.
module des_round_seq #(
  parameter int NUM_ROUNDS = 16,
  parameter int KEY_W      = 48
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             decrypt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      data_in,
  output logic [3:0]       subkey_idx,
  input  logic [KEY_W-1:0] subkey_in,
  output logic [31:0]      f_r_out,
  output logic [KEY_W-1:0] f_key_out,
  input  logic [31:0]      f_result_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      data_out,
  output logic             busy
`ifdef DES_ROUND_SEQ_ABORT_EN
  ,
  input  logic             abort
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST  = 5'(NUM_ROUNDS - 1);
  localparam logic [3:0] LAST4 = 4'(NUM_ROUNDS - 1);

  state_t      state;
  logic [31:0] l_q;
  logic [31:0] r_q;
  logic [4:0]  rc;
  logic        dir;
  logic        abort_w;
  logic [3:0]  k_next;
  logic [3:0]  idx_next;

`ifdef DES_ROUND_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign f_r_out   = r_q;
  assign f_key_out = subkey_in;
  assign data_out  = {r_q, l_q};

  // Index for the round after this one, precomputed so the
  // subkey request is always a register output.
  always_comb begin
    k_next   = rc[3:0] + 4'd1;
    idx_next = dir ? (LAST4 - k_next) : k_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      l_q        <= '0;
      r_q        <= '0;
      rc         <= '0;
      dir        <= 1'b0;
      subkey_idx <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else if (abort_w && state != S_IDLE) begin
      state      <= S_IDLE;
      l_q        <= '0;
      r_q        <= '0;
      rc         <= '0;
      subkey_idx <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            state      <= S_ROUND;
            l_q        <= data_in[63:32];
            r_q        <= data_in[31:0];
            dir        <= decrypt;
            rc         <= '0;
            subkey_idx <= decrypt ? LAST4 : 4'd0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_ROUND: begin
          l_q <= r_q;
          r_q <= l_q ^ f_result_in;
          if (rc == LAST) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            rc         <= rc + 5'd1;
            subkey_idx <= idx_next;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_seq.sv
// Self-checking bench for des_round_seq with a full DES reference model.
// Supplies the f-function and key schedule; abort test under DES_ROUND_SEQ_ABORT_EN.
module tb_des_round_seq;

  logic        clk;
  logic        n_rst;
  logic        decrypt;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data_in;
  logic [3:0]  subkey_idx;
  logic [47:0] subkey_in;
  logic [31:0] f_r_out;
  logic [47:0] f_key_out;
  logic [31:0] f_result_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] data_out;
  logic        busy;
`ifdef DES_ROUND_SEQ_ABORT_EN
  logic        abort;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int ip_t [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                    62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int fp_t [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                    38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                    36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                    34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  int e_t [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,
                   14,15,16,17,16,17,18,19,20,21,20,21,22,23,24,25,
                   24,25,26,27,28,29,28,29,30,31,32,1};
  int p_t [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
                     10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,
                     23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,
                     44,49,39,56,34,53,46,42,50,36,29,32};
  int sh_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sb [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
      0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
      15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
      3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
      13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
      13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
      1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
      13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
      3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
      14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
      11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
      10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
      4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
      13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
      6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
      1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
      2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  logic [47:0] ks [16];
  logic [3:0]  idx_log [$];
  logic [63:0] exp_q [$];

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-ip_t[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-fp_t[i]];
    return y;
  endfunction

  function automatic logic [31:0] f_fn(input logic [31:0] r,
                                       input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  six;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-e_t[i]];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      six = e[47-6*j -: 6];
      s[31-4*j -: 4] = 4'(sb[j][{six[5], six[0], six[4:1]}]);
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-p_t[i]];
    return y;
  endfunction

  task automatic set_key(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < sh_t[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int b = 0; b < 48; b++) ks[i][47-b] = cd[56-pc2_t[b]];
    end
  endtask

  // Sixteen Feistel rounds on an IP-domain block; result is {R16,L16}.
  function automatic logic [63:0] rounds(input logic [63:0] blk,
                                         input logic dec);
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] t;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_fn(r, dec ? ks[15-i] : ks[i]);
      l = t;
    end
    return {r, l};
  endfunction

  function automatic logic [63:0] pack_idx();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < idx_log.size() && i < 16; i++)
      v = {v[59:0], idx_log[i]};
    return v;
  endfunction

  assign subkey_in   = ks[subkey_idx];
  assign f_result_in = f_fn(f_r_out, f_key_out);

  des_round_seq dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .decrypt    (decrypt),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .subkey_idx (subkey_idx),
    .subkey_in  (subkey_in),
    .f_r_out    (f_r_out),
    .f_key_out  (f_key_out),
    .f_result_in(f_result_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .busy       (busy)
`ifdef DES_ROUND_SEQ_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [63:0] blk, input logic dec,
                           output logic [63:0] res, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      step();
      w++;
    end
    chk("rdy_wait", 64'(in_ready), 64'd1);
    data_in  = blk;
    decrypt  = dec;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom};
    decrypt  = ~dec;
    idx_log.delete();
    lat = 0;
    while (!out_valid && lat < 40) begin
      idx_log.push_back(subkey_idx);
      chk("rnd_flags", 64'({busy, in_ready}), 64'b10);
      step();
      lat++;
    end
    res = data_out;
  endtask

  logic [63:0] res;
  logic [63:0] res2;
  logic [63:0] blk;
  logic [63:0] xb;
  logic [63:0] pt;
  logic [63:0] ev;
  logic [63:0] bl [3];
  int          lat;
  int          cyc;
  int          sent;
  int          got;
  int          last_acc;
  logic        acc;
  logic        seen;

  initial begin
    n_rst     = 1'b1;
    decrypt   = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b1;
`ifdef DES_ROUND_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    #1 n_rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_idx", 64'(subkey_idx), 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_f_r", 64'(f_r_out), 64'd0);
    step();
    step();
    n_rst = 1'b1;

    // Known-answer encrypt and decrypt
    set_key(64'h133457799BBCDFF1);
    pt = 64'h0123456789ABCDEF;
    run_block(ip(pt), 1'b0, res, lat);
    chk("enc_ct", fp(res), 64'h85E813540F0AB405);
    chk("enc_lat", 64'(lat), 64'd16);
    chk("enc_idx", pack_idx(), 64'h0123456789ABCDEF);
    step();
    chk("enc_rel", 64'({out_valid, in_ready, busy}), 64'b010);

    run_block(ip(64'h85E813540F0AB405), 1'b1, res, lat);
    chk("dec_pt", fp(res), 64'h0123456789ABCDEF);
    chk("dec_lat", 64'(lat), 64'd16);
    chk("dec_idx", pack_idx(), 64'hFEDCBA9876543210);
    step();

    // Random keys, encrypt then decrypt round trip
    for (int n = 0; n < 3; n++) begin
      set_key({$urandom, $urandom});
      pt = {$urandom, $urandom};
      run_block(ip(pt), 1'b0, res, lat);
      chk("rt_enc", res, rounds(ip(pt), 1'b0));
      step();
      run_block(res, 1'b1, res2, lat);
      chk("rt_dec", fp(res2), pt);
      step();
    end

    // Output backpressure, then a waiting in_valid accepted after release
    out_ready = 1'b0;
    blk = {$urandom, $urandom};
    run_block(blk, 1'b0, res, lat);
    chk("bp_lat", 64'(lat), 64'd16);
    chk("bp_res", res, rounds(blk, 1'b0));
    xb       = {$urandom, $urandom};
    in_valid = 1'b1;
    data_in  = xb;
    decrypt  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_data", data_out, res);
      chk("bp_flags", 64'({out_valid, in_ready, busy}), 64'b101);
    end
    out_ready = 1'b1;
    step();
    chk("bp_rel", 64'({out_valid, in_ready, busy}), 64'b010);
    step();
    chk("bp_acc", 64'({in_ready, busy}), 64'b01);
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom};
    decrypt  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("bp_lat2", 64'(lat), 64'd16);
    chk("bp_res2", data_out, rounds(xb, 1'b1));
    step();

    // Back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 3; i++) bl[i] = {$urandom, $urandom};
    data_in  = bl[0];
    decrypt  = 1'($urandom);
    in_valid = 1'b1;
    cyc = 0;
    sent = 0;
    got = 0;
    last_acc = -1;
    while (got < 3 && cyc < 200) begin
      acc = in_ready && in_valid;
      if (acc) begin
        exp_q.push_back(rounds(data_in, decrypt));
        if (last_acc >= 0)
          chk("b2b_gap", 64'(cyc - last_acc), 64'd18);
        last_acc = cyc;
        sent++;
      end
      step();
      cyc++;
      if (acc) begin
        if (sent < 3) begin
          data_in = bl[sent];
          decrypt = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        ev = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        chk("b2b_data", data_out, ev);
        got++;
      end
    end
    chk("b2b_count", 64'(got), 64'd3);
    in_valid = 1'b0;
    step();

    // Reset pulsed mid-run at rc=7
    blk = {$urandom, $urandom};
    data_in  = blk;
    decrypt  = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("rm_idx", 64'(subkey_idx), 64'd7);
    n_rst = 1'b0;
    #1;
    chk("rm_flags", 64'({out_valid, in_ready, busy}), 64'b010);
    chk("rm_data", data_out, 64'd0);
    chk("rm_idx0", 64'(subkey_idx), 64'd0);
    chk("rm_f_r", 64'(f_r_out), 64'd0);
    #1 n_rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      seen = seen | out_valid;
    end
    chk("rm_noout", 64'(seen), 64'd0);
    blk = {$urandom, $urandom};
    run_block(blk, 1'b1, res, lat);
    chk("rm_next", res, rounds(blk, 1'b1));
    chk("rm_lat", 64'(lat), 64'd16);
    step();

`ifdef DES_ROUND_SEQ_ABORT_EN
    // Abort at rc=4 drops the block
    blk = {$urandom, $urandom};
    data_in  = blk;
    decrypt  = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("ab_idx", 64'(subkey_idx), 64'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_flags", 64'({out_valid, in_ready, busy}), 64'b010);
    chk("ab_data", data_out, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      seen = seen | out_valid;
    end
    chk("ab_noout", 64'(seen), 64'd0);
    blk = {$urandom, $urandom};
    run_block(blk, 1'b0, res, lat);
    chk("ab_next", res, rounds(blk, 1'b0));
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
